clk_div_ctrl: RTL and testbench

- Synchronous, fully single-clock replacement and controller for the ripple divider chain. No derived clocks.
- One free-running counter produces a one-cycle enable tick and a 50% square wave at f_clk / 2^(sel+1).
  - Example: at 50 MHz, sel=0 gives 25 MHz and sel=9 gives 48.828125 kHz.
- The rate is changed at runtime through a valid/ready handshake. A new rate is applied only at a period boundary, so the outputs never glitch or produce a short period.
- Sits between the board clock and downstream consumers such as display multiplexing, debouncers and timers.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_cnt.sv | 24 ++
 rtl/clk_div_ctrl.sv | 112 +++++++++++
 tb/tb_clk_div_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the synchronous clock divider controller:
// state encoding, default sizing and the rate-index helpers.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned RST_SEL_DEF = 9;

  // Largest usable index is cnt_w-1; anything above is pinned to it.
  function automatic int unsigned clamp_sel(input int unsigned s, input int unsigned cnt_w);
    return (s >= cnt_w) ? cnt_w - 1 : s;
  endfunction

  // Terminal-count mask (2 << s) - 1, wide enough for any counter up to 32 bits.
  function automatic logic [32:0] sel_mask(input int unsigned s);
    return (33'd2 << s) - 33'd1;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Free-running divider counter with synchronous clear, enable and
// terminal-count detect against a caller-supplied mask.
module clk_div_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] mask,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == mask);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Single-clock divider controller: tick and square-wave outputs at
// f_clk / 2^(sel_act+1), with glitch-free rate changes via valid/ready.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned RST_SEL = RST_SEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic             tick,
  output logic             sq_out,
  output logic [SEL_W-1:0] sel_act,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_pend, sel_pend_nxt, sel_act_nxt, sel_clamped;
  logic             tick_nxt, sq_nxt;
  logic             cnt_en, cnt_clr, tc, sq_bit, xfer;
  logic [CNT_W-1:0] mask, cnt;

  assign sel_clamped = SEL_W'(clamp_sel(32'(sel), CNT_W));
  assign mask        = CNT_W'(sel_mask(32'(sel_act)));
  // mask ^ (mask >> 1) isolates bit sel_act, i.e. the half-period bit of cnt.
  assign sq_bit      = |(cnt & (mask ^ (mask >> 1)));
  assign xfer        = sel_valid && sel_ready;
  assign busy        = (state == ST_RUN) || (state == ST_PEND);

  clk_div_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .mask (mask),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_comb begin
    state_nxt    = state;
    sel_act_nxt  = sel_act;
    sel_pend_nxt = sel_pend;
    tick_nxt     = 1'b0;
    sq_nxt       = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (xfer) sel_act_nxt = sel_clamped;
        if (run)  state_nxt   = ST_RUN;
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt = ST_IDLE;
          if (xfer) sel_act_nxt = sel_clamped;
        end else begin
          cnt_en   = 1'b1;
          cnt_clr  = 1'b0;
          tick_nxt = tc;
          sq_nxt   = sq_bit;
          if (xfer) begin
            sel_pend_nxt = sel_clamped;
            state_nxt    = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!run) begin
          state_nxt   = ST_IDLE;
          sel_act_nxt = sel_pend;
        end else begin
          cnt_en   = 1'b1;
          cnt_clr  = 1'b0;
          tick_nxt = tc;
          sq_nxt   = sq_bit;
          if (tc) begin
            sel_act_nxt = sel_pend;
            state_nxt   = ST_RUN;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_act   <= SEL_W'(RST_SEL);
      sel_pend  <= '0;
      tick      <= 1'b0;
      sq_out    <= 1'b0;
      sel_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      sel_act   <= sel_act_nxt;
      sel_pend  <= sel_pend_nxt;
      tick      <= tick_nxt;
      sq_out    <= sq_nxt;
      sel_ready <= (state_nxt != ST_PEND);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-computed
// periods, latencies and handshake timing.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, sel_valid;
  logic [4:0] sel;
  logic       sel_ready, tick, sq_out, busy;
  logic [4:0] sel_act;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W   (16),
    .SEL_W   (5),
    .RST_SEL (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .tick      (tick),
    .sq_out    (sq_out),
    .sel_act   (sel_act),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer_idle(input logic [4:0] s);
    sel       = s;
    sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n < budget);
  endtask

  // Starts on a tick sample; expects p/2 low samples then p/2 high, ending on the next tick.
  task automatic measure(input string tag, input int p);
    int   n, highs;
    logic first;
    n = 0;
    highs = 0;
    first = 1'b1;
    do begin
      step(1);
      n++;
      if (n == 1) first = sq_out;
      if (sq_out) highs++;
    end while (!tick && n < 4 * p);
    check({tag, "_period"}, n, p);
    check({tag, "_high"}, highs, p / 2);
    check({tag, "_first_low"}, first, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; sel_valid = 1'b0; sel = '0;
    step(2);
    check("rst_sel_act", sel_act, 9);
    check("rst_ready", sel_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_sq", sq_out, 0);

    // Defaults: sel=9, first tick after run latency of 1 + 1024
    rst = 1'b0; run = 1'b1;
    wait_tick(1100, n);
    check("t1_first_tick", n, 1025);
    check("t1_sel_act", sel_act, 9);
    check("t1_busy", busy, 1);
    measure("t1", 1024);

    // Fastest rate
    run = 1'b0;
    step(1);
    check("t2_idle_busy", busy, 0);
    check("t2_idle_tick", tick, 0);
    check("t2_idle_sq", sq_out, 0);
    xfer_idle(5'd0);
    check("t2_sel_act", sel_act, 0);
    run = 1'b1;
    wait_tick(10, n);
    check("t2_first_tick", n, 3);
    measure("t2", 2);

    // Mid-period change at cnt=5, sel 3 -> 1
    run = 1'b0;
    step(1);
    xfer_idle(5'd3);
    run = 1'b1;
    step(6);
    sel = 5'd1; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    check("t3_ready_low", sel_ready, 0);
    check("t3_sel_act_old", sel_act, 3);
    wait_tick(30, n);
    check("t3_old_tick", n, 10);
    check("t3_sel_act_new", sel_act, 1);
    check("t3_ready_back", sel_ready, 1);
    measure("t3", 4);

    // Transfer coinciding with TC (cnt=15 at sel=3)
    run = 1'b0;
    step(1);
    xfer_idle(5'd3);
    run = 1'b1;
    step(16);
    sel = 5'd2; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    check("t4_tc_tick", tick, 1);
    check("t4_ready_low", sel_ready, 0);
    check("t4_sel_act_old", sel_act, 3);
    wait_tick(40, n);
    check("t4_extra_period", n, 16);
    check("t4_sel_act_new", sel_act, 2);
    measure("t4", 8);

    // Leaving PEND via run=0 applies the pending index
    run = 1'b0;
    step(1);
    xfer_idle(5'd2);
    run = 1'b1;
    step(3);
    sel = 5'd5; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    check("t5_ready_low", sel_ready, 0);
    run = 1'b0;
    step(1);
    check("t5_sel_act", sel_act, 5);
    check("t5_busy", busy, 0);
    check("t5_ready", sel_ready, 1);
    check("t5_tick", tick, 0);
    check("t5_sq", sq_out, 0);

    // Clamp 31 -> 15, then stop at cnt=100
    xfer_idle(5'd31);
    check("t6_clamp", sel_act, 15);
    run = 1'b1;
    step(101);
    check("t6_run_tick", tick, 0);
    check("t6_run_sq", sq_out, 0);
    check("t6_run_busy", busy, 1);
    run = 1'b0;
    step(1);
    check("t6_stop_tick", tick, 0);
    check("t6_stop_sq", sq_out, 0);
    check("t6_stop_busy", busy, 0);
    run = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sq_out && n < 40000);
    check("t6_sq_rise", n, 32770);
    check("t6_sq_rise_tick", tick, 0);
    run = 1'b0;
    step(1);

    // Reset while PEND discards the pending index
    xfer_idle(5'd2);
    run = 1'b1;
    step(3);
    sel = 5'd4; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    check("t7_ready_low", sel_ready, 0);
    rst = 1'b1;
    step(1);
    check("t7_sel_act", sel_act, 9);
    check("t7_ready", sel_ready, 1);
    check("t7_busy", busy, 0);
    check("t7_tick", tick, 0);
    check("t7_sq", sq_out, 0);
    rst = 1'b0;
    wait_tick(1100, n);
    check("t7_first_tick", n, 1025);
    check("t7_sel_act_run", sel_act, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
